// File: rtl/df_mid_lsdc_pkg.sv
// df_mid_lsdc_pkg: shared helpers for the age-ordered pick block.
package df_mid_lsdc_pkg;
   // Packed upper-triangle index of pair (i,j); argument order does not matter.
   function automatic int tri_idx(input int i, input int j, input int size);
      int a;
      int b;
      a = i < j ? i : j;
      b = i < j ? j : i;
      return a * size - a * (a + 1) / 2 + b - a - 1;
   endfunction
   function automatic int popcount(input logic [63:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 64; i++) n += int'(v[i]);
      return n;
   endfunction
   function automatic int cntw(input int size);
      return $clog2(size + 1);
   endfunction
endpackage

// File: rtl/df_mid_lsdc_agepick2_if.sv
// df_mid_lsdc_agepick2_if: allocation/flush/pick bundle between scheduler queue and age picker.
interface df_mid_lsdc_agepick2_if #(
   parameter int SIZE  = 8,
   parameter int ALLOC = 2,
   parameter int PICK  = 2,
   parameter int CNTW  = $clog2(SIZE + 1)
);
   logic [ALLOC-1:0]           AllocVal;
   logic [ALLOC-1:0][SIZE-1:0] AllocIdx;
   logic [SIZE-1:0]            DeallocVec;
   logic                       FlushVal;
   logic [SIZE-1:0]            FlushIdx;
   logic [SIZE-1:0]            Pickable;
   logic [SIZE-1:0]            Valid;
   logic [PICK-1:0][SIZE-1:0]  Oldest;
   logic [SIZE-1:0]            Youngest;
   logic [CNTW-1:0]            Count;
   logic                       AllocErr;
   modport master (
      output AllocVal, AllocIdx, DeallocVec, FlushVal, FlushIdx, Pickable,
      input  Valid, Oldest, Youngest, Count, AllocErr
   );
   modport slave (
      input  AllocVal, AllocIdx, DeallocVec, FlushVal, FlushIdx, Pickable,
      output Valid, Oldest, Youngest, Count, AllocErr
   );
endinterface

// File: rtl/df_mid_lsdc_agerank.sv
// df_mid_lsdc_agerank: ranks candidates by age, yielding the PICK oldest and the youngest one-hot.
module df_mid_lsdc_agerank
   import df_mid_lsdc_pkg::*;
#(
   parameter int SIZE = 8,
   parameter int PICK = 2
) (
   input  logic [SIZE-1:0]            cand,
   input  logic [SIZE-1:0][SIZE-1:0]  older,
   output logic [PICK-1:0][SIZE-1:0]  oldest,
   output logic [SIZE-1:0]            youngest
);
   logic [SIZE-1:0] col;
   int              rank;
   always_comb begin
      oldest   = '0;
      youngest = '0;
      col      = '0;
      rank     = 0;
      for (int i = 0; i < SIZE; i++) begin
         for (int j = 0; j < SIZE; j++) col[j] = older[j][i];
         rank = popcount(64'(cand & col));
         for (int p = 0; p < PICK; p++) oldest[p][i] = cand[i] & (rank == p);
         youngest[i] = cand[i] & ~|(cand & older[i]);
      end
   end
endmodule

// File: rtl/df_mid_lsdc_agepick2.sv
// df_mid_lsdc_agepick2: triangular age matrix with entry valids, alloc/dealloc/flush-younger and multi-rank pick.
module df_mid_lsdc_agepick2
   import df_mid_lsdc_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int ALLOC = 2,
   parameter int PICK  = 2
) (
   input logic                  KCLK_AR,
   input logic                  Reset,
   df_mid_lsdc_agepick2_if.slave bus
);
   localparam int NT   = SIZE * (SIZE - 1) / 2;
   localparam int CNTW = cntw(SIZE);
   logic [NT-1:0]               age_q, age_n;
   logic [SIZE-1:0]             valid_q, valid_n;
   logic                        err_q, err_n;
   logic [SIZE-1:0][SIZE-1:0]   older;
   logic [SIZE-1:0]             kill, survive, alloc_any;
   int                          lane [SIZE];
   logic [PICK-1:0][SIZE-1:0]   oldest;
   logic [SIZE-1:0]             youngest;
   always_comb begin
      older = '0;
      for (int i = 0; i < SIZE; i++)
         for (int j = 0; j < SIZE; j++)
            older[i][j] = i == j ? 1'b0 : i < j ? age_q[tri_idx(i, j, SIZE)] : ~age_q[tri_idx(i, j, SIZE)];
   end
   // Freeing resolves first so a same-cycle alloc can reuse the entry; higher lanes overwrite lower ones.
   always_comb begin
      kill      = '0;
      alloc_any = '0;
      err_n     = 1'b0;
      for (int e = 0; e < SIZE; e++) lane[e] = 0;
      for (int j = 0; j < SIZE; j++)
         for (int a = 0; a < SIZE; a++)
            kill[j] = kill[j] | (bus.FlushVal & bus.FlushIdx[a] & valid_q[a] & valid_q[j] & older[a][j]);
      survive = valid_q & ~(bus.DeallocVec | kill);
      for (int k = 0; k < ALLOC; k++)
         for (int e = 0; e < SIZE; e++)
            if (bus.AllocVal[k] & bus.AllocIdx[k][e]) begin
               err_n        = err_n | survive[e] | alloc_any[e];
               alloc_any[e] = 1'b1;
               lane[e]      = k;
            end
      valid_n = survive | alloc_any;
      age_n   = age_q;
      for (int i = 0; i < SIZE; i++)
         for (int j = i + 1; j < SIZE; j++)
            age_n[tri_idx(i, j, SIZE)] = alloc_any[i] & alloc_any[j] ? lane[i] < lane[j] :
                                         alloc_any[i] ? 1'b0 :
                                         alloc_any[j] ? 1'b1 : age_q[tri_idx(i, j, SIZE)];
   end
   always_ff @(posedge KCLK_AR) begin
      if (Reset) begin
         age_q   <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         age_q   <= age_n;
         valid_q <= valid_n;
         err_q   <= err_n;
      end
   end
   df_mid_lsdc_agerank #(.SIZE(SIZE), .PICK(PICK)) u_rank (
      .cand     (valid_q & bus.Pickable),
      .older    (older),
      .oldest   (oldest),
      .youngest (youngest)
   );
   assign bus.Valid    = valid_q;
   assign bus.Count    = CNTW'(popcount(64'(valid_q)));
   assign bus.AllocErr = err_q;
   assign bus.Oldest   = oldest;
   assign bus.Youngest = youngest;
endmodule
